travel_plan_seq: RTL

Travel-plan sequencer inside `MazeRunner`, directly downstream of the UART receive wrapper that delivers the 16-bit travel-plan word sent by `CommMaster`. It holds the plan as eight 2-bit maneuvers, detects line gaps from `line_present`, and applies one maneuver per gap by updating the desired heading. It also drives `go` and `buzz_en` to the motion and piezo blocks, pausing on bumper obstruction.

---
 rtl/maze_pkg.sv | 43 ++++
 rtl/travel_plan_seq_run_len_cnt.sv | 31 +++
 rtl/travel_plan_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared types and constants for the MazeRunner travel-plan path.
// Maneuver codes, sequencer states and the heading-delta helper live here.
package maze_pkg;

  localparam int CNT_W        = 16;
  localparam int HDG_W        = 13;
  localparam int PLAN_LEN     = 8;
  localparam int DEF_VEER_ANG = 350;
  localparam int DEF_TURN_ANG = 1800;

  typedef enum logic [1:0] {
    STOP   = 2'b00,
    VEER_R = 2'b01,
    VEER_L = 2'b10,
    TURN   = 2'b11
  } maneuver_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FOLLOW = 2'd1,
    S_REACQ  = 2'd2,
    S_HALT   = 2'd3
  } seq_state_t;

  // A turn-around swings the same way as the most recent veer.
  function automatic logic signed [HDG_W-1:0] hdg_delta(
    input maneuver_t               m,
    input logic                    last_left,
    input logic signed [HDG_W-1:0] veer,
    input logic signed [HDG_W-1:0] turn
  );
    logic signed [HDG_W-1:0] d;
    d = '0;
    case (m)
      VEER_R:  d = veer;
      VEER_L:  d = -veer;
      TURN:    d = last_left ? -turn : turn;
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/travel_plan_seq_run_len_cnt.sv
// Saturating run-length counter: counts while count_en is high, zeroes when it drops.
// hold freezes the value; clr wins over everything.
module run_len_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         hold,
  input  logic         count_en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)           cnt_d = '0;
    else if (hold)     cnt_d = cnt_q;
    else if (count_en) cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    else               cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/travel_plan_seq.sv
// Travel-plan sequencer: applies one 2-bit maneuver per qualified line gap
// and gates motion/buzzer on bumper obstruction.
module travel_plan_seq
  import maze_pkg::*;
#(
  parameter int GAP_CLKS   = 4096,
  parameter int REACQ_CLKS = 4096,
  parameter int VEER_ANG   = DEF_VEER_ANG,
  parameter int TURN_ANG   = DEF_TURN_ANG
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             cmd,
  input  logic                    cmd_rdy,
  output logic                    clr_cmd_rdy,
  input  logic                    line_present,
  input  logic                    BMPL_n,
  input  logic                    BMPR_n,
  output logic signed [HDG_W-1:0] dsrd_hdg,
  output logic                    go,
  output logic                    buzz_en,
  output logic                    plan_done
);

  localparam logic [CNT_W-1:0]        GAP_TH   = CNT_W'(GAP_CLKS);
  localparam logic [CNT_W-1:0]        REACQ_TH = CNT_W'(REACQ_CLKS);
  localparam logic signed [HDG_W-1:0] VEER_D   = HDG_W'(VEER_ANG);
  localparam logic signed [HDG_W-1:0] TURN_D   = HDG_W'(TURN_ANG);

  seq_state_t state_q, state_d;
  logic [15:0] cmd_q, cmd_d, plan_q, plan_d;
  logic cmd_rdy_q, cmd_rdy_d, rdy_prev_q, rdy_prev_d, bmp_q, bmp_d;
  logic [3:0] idx_q, idx_d;
  logic last_left_q, last_left_d;
  logic signed [HDG_W-1:0] hdg_q, hdg_d;
  logic go_q, go_d, buzz_q, buzz_d, done_q, done_d, clr_q, clr_d;
  logic [CNT_W-1:0] gap_cnt, rq_cnt;
  logic cmd_new, obst, gap_fire, reacq_fire, active_d;
  maneuver_t cur_man;

  // The plan level stays high until the ack round-trips, so act on its rising edge only.
  assign cmd_new    = cmd_rdy_q & ~rdy_prev_q;
  assign obst       = bmp_q & ((state_q == S_FOLLOW) || (state_q == S_REACQ));
  assign cur_man    = maneuver_t'(plan_q[1:0]);
  assign gap_fire   = (state_q == S_FOLLOW) && (gap_cnt >= GAP_TH) && !obst && !cmd_new;
  assign reacq_fire = (state_q == S_REACQ) && (rq_cnt >= REACQ_TH) && !obst && !cmd_new;

  run_len_cnt #(.W(CNT_W)) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cmd_new | gap_fire),
    .hold     (obst),
    .count_en ((state_q == S_FOLLOW) && !line_present),
    .cnt      (gap_cnt)
  );

  run_len_cnt #(.W(CNT_W)) u_reacq_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cmd_new | reacq_fire),
    .hold     (obst),
    .count_en ((state_q == S_REACQ) && line_present),
    .cnt      (rq_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: if (cmd_new) state_d = S_FOLLOW;
      S_FOLLOW: begin
        if (cmd_new)       state_d = S_FOLLOW;
        else if (gap_fire) state_d = (cur_man == STOP) ? S_HALT : S_REACQ;
      end
      S_REACQ: begin
        if (cmd_new)         state_d = S_FOLLOW;
        else if (reacq_fire) state_d = (idx_q == 4'(PLAN_LEN)) ? S_HALT : S_FOLLOW;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_d       = cmd;
    cmd_rdy_d   = cmd_rdy;
    rdy_prev_d  = cmd_rdy_q;
    bmp_d       = ~BMPL_n | ~BMPR_n;
    plan_d      = plan_q;
    idx_d       = idx_q;
    hdg_d       = hdg_q;
    last_left_d = last_left_q;
    if (cmd_new) begin
      plan_d = cmd_q;
      idx_d  = '0;
    end else if (gap_fire && (cur_man != STOP)) begin
      plan_d = plan_q >> 2;
      idx_d  = idx_q + 4'd1;
      hdg_d  = hdg_q + hdg_delta(cur_man, last_left_q, VEER_D, TURN_D);
      if (cur_man == VEER_R) last_left_d = 1'b0;
      if (cur_man == VEER_L) last_left_d = 1'b1;
    end
  end

  always_comb begin
    active_d = (state_d == S_FOLLOW) || (state_d == S_REACQ);
    go_d     = active_d && !bmp_q;
    buzz_d   = active_d && bmp_q;
    done_d   = (state_d == S_HALT);
    clr_d    = cmd_new;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q <= '0; cmd_rdy_q <= 1'b0; rdy_prev_q <= 1'b0; bmp_q <= 1'b0;
      plan_q <= '0; idx_q <= '0; hdg_q <= '0; last_left_q <= 1'b0;
      go_q <= 1'b0; buzz_q <= 1'b0; done_q <= 1'b0; clr_q <= 1'b0;
    end else begin
      cmd_q <= cmd_d; cmd_rdy_q <= cmd_rdy_d; rdy_prev_q <= rdy_prev_d; bmp_q <= bmp_d;
      plan_q <= plan_d; idx_q <= idx_d; hdg_q <= hdg_d; last_left_q <= last_left_d;
      go_q <= go_d; buzz_q <= buzz_d; done_q <= done_d; clr_q <= clr_d;
    end
  end

  assign dsrd_hdg    = hdg_q;
  assign go          = go_q;
  assign buzz_en     = buzz_q;
  assign plan_done   = done_q;
  assign clr_cmd_rdy = clr_q;

endmodule
